// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feedforward convolutional encoder, K selectable 3..6.
// Per-frame K latch, zero tail flush, and valid/ready on both sides.
module conv_encoder_sys (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] choose_constraint_length,
  input  logic       data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [1:0] encoded_bits,
  output logic       encoded_valid,
  output logic       encoded_last,
  input  logic       encoded_ready,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_t;

  state_t     state, state_nx;
  logic [2:0] k_q, k_nx, k_eff;
  logic [4:0] hist_q, hist_nx;
  logic [2:0] tail_q, tail_nx;
  logic [1:0] bits_nx, sym;
  logic       valid_nx, last_nx, busy_nx;
  logic       k_ok, k_live_ok, slot_free;
  logic       accept, u_in;

  // Masks are the generators bit-reversed: mask[j] taps u_{t-j}.
  function automatic logic [1:0] encode(
    input logic [2:0] k,
    input logic [5:0] w
  );
    logic [5:0] m0, m1;
    m0 = '0;
    m1 = '0;
    unique case (k)
      3'd3: begin m0 = 6'b000111; m1 = 6'b000101; end
      3'd4: begin m0 = 6'b001011; m1 = 6'b001111; end
      3'd5: begin m0 = 6'b011001; m1 = 6'b010111; end
      3'd6: begin m0 = 6'b110101; m1 = 6'b101111; end
      default: ;
    endcase
    return {^(m0 & w), ^(m1 & w)};
  endfunction

  assign k_live_ok = (choose_constraint_length >= 3'd3) &&
                     (choose_constraint_length <= 3'd6);
  assign k_eff     = (state == IDLE) ? choose_constraint_length : k_q;
  assign k_ok      = (k_eff >= 3'd3) && (k_eff <= 3'd6);
  assign slot_free = !encoded_valid || encoded_ready;
  assign data_ready = slot_free && (state != TAIL) && k_ok;
  assign cfg_err   = (state == IDLE) && !k_live_ok;
  assign accept    = data_valid && data_ready;
  assign u_in      = (state == TAIL) ? 1'b0 : data_in;
  assign sym       = encode(k_eff, {hist_q, u_in});

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k_q           <= '0;
      hist_q        <= '0;
      tail_q        <= '0;
      encoded_bits  <= '0;
      encoded_valid <= 1'b0;
      encoded_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      k_q           <= k_nx;
      hist_q        <= hist_nx;
      tail_q        <= tail_nx;
      encoded_bits  <= bits_nx;
      encoded_valid <= valid_nx;
      encoded_last  <= last_nx;
      busy          <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k_q;
    hist_nx  = hist_q;
    tail_nx  = tail_q;
    bits_nx  = encoded_bits;
    valid_nx = encoded_valid;
    last_nx  = encoded_last;
    busy_nx  = busy;
    if (encoded_valid && encoded_ready) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (accept) begin
          k_nx     = choose_constraint_length;
          bits_nx  = sym;
          valid_nx = 1'b1;
          last_nx  = 1'b0;
          hist_nx  = {hist_q[3:0], u_in};
          busy_nx  = 1'b1;
          if (data_last) begin
            state_nx = TAIL;
            tail_nx  = k_eff - 3'd1;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          bits_nx  = sym;
          valid_nx = 1'b1;
          last_nx  = 1'b0;
          hist_nx  = {hist_q[3:0], u_in};
          if (data_last) begin
            state_nx = TAIL;
            tail_nx  = k_eff - 3'd1;
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          bits_nx  = sym;
          valid_nx = 1'b1;
          last_nx  = 1'b0;
          hist_nx  = {hist_q[3:0], u_in};
          tail_nx  = tail_q - 3'd1;
          if (tail_q == 3'd1) begin
            last_nx  = 1'b1;
            hist_nx  = '0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
